// File: rtl/shot_link_tx.sv
// Frames the gun controller's shot state into a 7-byte UART packet every
// PERIOD_FRAMES vsync rising edges, streamed over a valid/ready byte port.
module shot_link_tx #(
   parameter logic [7:0] SYNC_BYTE     = 8'hA5,
   parameter int         PERIOD_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       vsync,
   input  logic [9:0] xpos_bullet,
   input  logic [9:0] ypos_bullet,
   input  logic [2:0] direction,
   input  logic       tank_hit,
   input  logic       obstacle_hit,
   input  logic [7:0] hp_enemy,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       pkt_sent,
   output logic [7:0] overrun_cnt
);

   localparam int            FW    = (PERIOD_FRAMES > 1) ? $clog2(PERIOD_FRAMES) : 1;
   localparam logic [FW-1:0] FLAST = FW'(PERIOD_FRAMES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state_q, state_d;
   logic          vsync_q;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          tankFlag_q, tankFlag_d, obstFlag_q, obstFlag_d;
   logic [9:0]    snapX_q, snapX_d, snapY_q, snapY_d;
   logic [2:0]    snapDir_q, snapDir_d;
   logic [7:0]    snapHp_q, snapHp_d;
   logic          snapTank_q, snapTank_d, snapObst_q, snapObst_d;
   logic [7:0]    txData_q, txData_d;
   logic          txValid_q, txValid_d, busy_q, busy_d, pktSent_q, pktSent_d;
   logic [7:0]    overrun_q, overrun_d;

   logic       vsyncEdge, trigger;
   logic [7:0] b1, b2, b3, b4, b5, b6, nextByte;
   logic [2:0] nextIdx;

   assign vsyncEdge = vsync & ~vsync_q;
   assign trigger   = vsyncEdge & enable & (fcnt_q == FLAST);

   assign b1 = {snapTank_q, snapObst_q, 1'b0, snapDir_q, snapX_q[9:8]};
   assign b2 = snapX_q[7:0];
   assign b3 = {6'b0, snapY_q[9:8]};
   assign b4 = snapY_q[7:0];
   assign b5 = snapHp_q;
   assign b6 = SYNC_BYTE ^ b1 ^ b2 ^ b3 ^ b4 ^ b5;
   assign nextIdx = idx_q + 3'd1;

   always_comb begin
      nextByte = SYNC_BYTE;
      case (nextIdx)
         3'd1:    nextByte = b1;
         3'd2:    nextByte = b2;
         3'd3:    nextByte = b3;
         3'd4:    nextByte = b4;
         3'd5:    nextByte = b5;
         3'd6:    nextByte = b6;
         default: nextByte = SYNC_BYTE;
      endcase
   end

   always_comb begin
      fcnt_d = fcnt_q;
      if (!enable)
         fcnt_d = '0;
      else if (vsyncEdge)
         fcnt_d = (fcnt_q == FLAST) ? '0 : fcnt_q + FW'(1);
   end

   // Hit flags stay sticky until a snapshot takes them; a pulse landing in the
   // snapshot cycle re-arms the flag for the following packet.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tankFlag_d = tankFlag_q | tank_hit;
      obstFlag_d = obstFlag_q | obstacle_hit;
      snapX_d    = snapX_q;
      snapY_d    = snapY_q;
      snapDir_d  = snapDir_q;
      snapHp_d   = snapHp_q;
      snapTank_d = snapTank_q;
      snapObst_d = snapObst_q;
      txData_d   = txData_q;
      txValid_d  = txValid_q;
      busy_d     = busy_q;
      pktSent_d  = 1'b0;
      overrun_d  = overrun_q;

      case (state_q)
         IDLE: begin
            if (trigger) begin
               snapX_d    = xpos_bullet;
               snapY_d    = ypos_bullet;
               snapDir_d  = direction;
               snapHp_d   = hp_enemy;
               snapTank_d = tankFlag_q;
               snapObst_d = obstFlag_q;
               tankFlag_d = tank_hit;
               obstFlag_d = obstacle_hit;
               idx_d      = 3'd0;
               txData_d   = SYNC_BYTE;
               txValid_d  = 1'b1;
               busy_d     = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (trigger && overrun_q != 8'hFF)
               overrun_d = overrun_q + 8'd1;
            if (txValid_q && tx_ready) begin
               if (idx_q == 3'd6) begin
                  txValid_d = 1'b0;
                  busy_d    = 1'b0;
                  pktSent_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  idx_d    = nextIdx;
                  txData_d = nextByte;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         vsync_q    <= 1'b0;
         fcnt_q     <= '0;
         idx_q      <= 3'd0;
         tankFlag_q <= 1'b0;
         obstFlag_q <= 1'b0;
         snapX_q    <= '0;
         snapY_q    <= '0;
         snapDir_q  <= '0;
         snapHp_q   <= '0;
         snapTank_q <= 1'b0;
         snapObst_q <= 1'b0;
         txData_q   <= '0;
         txValid_q  <= 1'b0;
         busy_q     <= 1'b0;
         pktSent_q  <= 1'b0;
         overrun_q  <= '0;
      end else begin
         state_q    <= state_d;
         vsync_q    <= vsync;
         fcnt_q     <= fcnt_d;
         idx_q      <= idx_d;
         tankFlag_q <= tankFlag_d;
         obstFlag_q <= obstFlag_d;
         snapX_q    <= snapX_d;
         snapY_q    <= snapY_d;
         snapDir_q  <= snapDir_d;
         snapHp_q   <= snapHp_d;
         snapTank_q <= snapTank_d;
         snapObst_q <= snapObst_d;
         txData_q   <= txData_d;
         txValid_q  <= txValid_d;
         busy_q     <= busy_d;
         pktSent_q  <= pktSent_d;
         overrun_q  <= overrun_d;
      end
   end

   assign tx_data     = txData_q;
   assign tx_valid    = txValid_q;
   assign busy        = busy_q;
   assign pkt_sent    = pktSent_q;
   assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_shot_link_tx.sv
// Directed bench for shot_link_tx: one instance with PERIOD_FRAMES=2 and one
// with PERIOD_FRAMES=1 share the stimulus; each step checks hand-computed bytes.
module tb_shot_link_tx;

   logic       clk = 1'b0;
   logic       rst, enable, vsync, tankHit, obstacleHit, txReady;
   logic [9:0] xpos, ypos;
   logic [2:0] direction;
   logic [7:0] hpEnemy;

   logic [7:0] txData2, overrun2, txData1, overrun1;
   logic       txValid2, busy2, pktSent2, txValid1, busy1, pktSent1;

   int testsRun  = 0;
   int failCount = 0;

   shot_link_tx #(.SYNC_BYTE(8'hA5), .PERIOD_FRAMES(2)) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .vsync(vsync),
      .xpos_bullet(xpos), .ypos_bullet(ypos), .direction(direction),
      .tank_hit(tankHit), .obstacle_hit(obstacleHit), .hp_enemy(hpEnemy),
      .tx_data(txData2), .tx_valid(txValid2), .tx_ready(txReady),
      .busy(busy2), .pkt_sent(pktSent2), .overrun_cnt(overrun2)
   );

   shot_link_tx #(.SYNC_BYTE(8'hA5), .PERIOD_FRAMES(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .vsync(vsync),
      .xpos_bullet(xpos), .ypos_bullet(ypos), .direction(direction),
      .tank_hit(tankHit), .obstacle_hit(obstacleHit), .hp_enemy(hpEnemy),
      .tx_data(txData1), .tx_valid(txValid1), .tx_ready(txReady),
      .busy(busy1), .pkt_sent(pktSent1), .overrun_cnt(overrun1)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic vsyncPulse;
      vsync = 1'b1;
      applyStimulus;
      vsync = 1'b0;
      applyStimulus;
   endtask

   // Drains dut2's packet from byte startByte on; readyPat bit (n%4) drives tx_ready.
   task automatic recvPacket(input string tag, input logic [55:0] exp,
                             input logic [3:0] readyPat, input int startByte);
      int p = 0;
      for (int k = startByte; k < 7; k++) begin
         int  waitCnt = 0;
         bit  done = 0;
         while (!done) begin
            txReady = readyPat[p % 4];
            p++;
            checkOutput($sformatf("%s_valid%0d", tag, k), {15'd0, txValid2}, 16'd1);
            checkOutput($sformatf("%s_b%0d", tag, k), {8'd0, txData2}, {8'd0, exp[55-8*k -: 8]});
            applyStimulus;
            if (txReady) done = 1;
            else begin
               waitCnt++;
               if (waitCnt > 20) begin
                  checkOutput($sformatf("%s_timeout%0d", tag, k), 16'd1, 16'd0);
                  done = 1;
               end
            end
         end
      end
      checkOutput({tag, "_pktSent"}, {15'd0, pktSent2}, 16'd1);
      checkOutput({tag, "_validLow"}, {15'd0, txValid2}, 16'd0);
      checkOutput({tag, "_busyLow"}, {15'd0, busy2}, 16'd0);
      txReady = 1'b1;
      applyStimulus;
      checkOutput({tag, "_pktSentPulse"}, {15'd0, pktSent2}, 16'd0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; vsync = 1'b0; tankHit = 1'b0; obstacleHit = 1'b0;
      txReady = 1'b1; xpos = '0; ypos = '0; direction = '0; hpEnemy = '0;
      applyStimulus;
      applyStimulus;
      rst = 1'b0;
      checkOutput("rst_txData",  {8'd0, txData2},  16'h0000);
      checkOutput("rst_txValid", {15'd0, txValid2}, 16'd0);
      checkOutput("rst_busy",    {15'd0, busy2},    16'd0);
      checkOutput("rst_pktSent", {15'd0, pktSent2}, 16'd0);
      checkOutput("rst_overrun", {8'd0, overrun2},  16'd0);

      // Basic packet with one tank hit collected before the trigger.
      xpos = 10'd300; ypos = 10'd200; direction = 3'd1; hpEnemy = 8'd135; enable = 1'b1;
      tankHit = 1'b1;
      applyStimulus;
      tankHit = 1'b0;
      vsyncPulse;
      checkOutput("t1_noTrigFirstEdge", {15'd0, txValid2}, 16'd0);
      vsync = 1'b1;
      applyStimulus;
      vsync = 1'b0;
      checkOutput("t1_busy", {15'd0, busy2}, 16'd1);
      recvPacket("t1", 56'hA5_85_2C_00_C8_87_43, 4'b1111, 0);

      // No new hits; obstacle pulse in the snapshot cycle is deferred.
      vsyncPulse;
      vsync = 1'b1; obstacleHit = 1'b1;
      applyStimulus;
      vsync = 1'b0; obstacleHit = 1'b0;
      recvPacket("t2", 56'hA5_05_2C_00_C8_87_C3, 4'b1111, 0);

      // Stalled handshake, pattern 1,0,0,1.
      vsyncPulse;
      vsync = 1'b1;
      applyStimulus;
      vsync = 1'b0;
      recvPacket("t3", 56'hA5_45_2C_00_C8_87_83, 4'b1001, 0);

      // Disabled for four frames, then enable drops during byte 3.
      enable = 1'b0;
      xpos = 10'd1023; ypos = 10'd515; direction = 3'd4; hpEnemy = 8'd0;
      for (int f = 0; f < 4; f++) begin
         vsyncPulse;
         checkOutput($sformatf("t5_idle%0d", f), {15'd0, txValid2}, 16'd0);
      end
      enable = 1'b1;
      vsyncPulse;
      vsync = 1'b1;
      applyStimulus;
      vsync = 1'b0;
      checkOutput("t5_b0", {8'd0, txData2}, 16'h00A5);
      applyStimulus;
      checkOutput("t5_b1", {8'd0, txData2}, 16'h0013);
      applyStimulus;
      checkOutput("t5_b2", {8'd0, txData2}, 16'h00FF);
      applyStimulus;
      enable = 1'b0;
      recvPacket("t5", 56'hA5_13_FF_02_03_00_48, 4'b1111, 3);
      vsyncPulse;
      vsyncPulse;
      checkOutput("t5_noNewPkt", {15'd0, txValid2}, 16'd0);

      // Reset while byte 4 is on the link.
      enable = 1'b1;
      vsyncPulse;
      vsync = 1'b1;
      applyStimulus;
      vsync = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus;
      checkOutput("t6_atB4", {8'd0, txData2}, 16'h0003);
      rst = 1'b1;
      applyStimulus;
      rst = 1'b0;
      checkOutput("t6_validLow", {15'd0, txValid2}, 16'd0);
      checkOutput("t6_busyLow",  {15'd0, busy2},    16'd0);
      checkOutput("t6_dataZero", {8'd0, txData2},   16'd0);
      vsyncPulse;
      checkOutput("t6_waitEdge", {15'd0, txValid2}, 16'd0);
      vsync = 1'b1;
      applyStimulus;
      vsync = 1'b0;
      recvPacket("t6", 56'hA5_13_FF_02_03_00_48, 4'b1111, 0);

      // PERIOD_FRAMES=1 overruns with the link stalled.
      rst = 1'b1;
      applyStimulus;
      rst = 1'b0;
      txReady = 1'b0;
      for (int e = 0; e < 3; e++) vsyncPulse;
      checkOutput("t4_pending",  {15'd0, txValid1}, 16'd1);
      checkOutput("t4_b0held",   {8'd0, txData1},   16'h00A5);
      checkOutput("t4_overrun2", {8'd0, overrun1},  16'd2);
      checkOutput("t4_p2overrun0", {8'd0, overrun2}, 16'd0);
      for (int e = 0; e < 300; e++) vsyncPulse;
      checkOutput("t4_saturate", {8'd0, overrun1}, 16'd255);
      checkOutput("t4_p2overrun150", {8'd0, overrun2}, 16'd150);
      checkOutput("t4_stillHeld", {8'd0, txData1}, 16'h00A5);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
